matmul3_sequencer: RTL and testbench
====================================

Name: matmul3_sequencer

Overview:
- Computes C = A * B for 3x3 matrices by time-multiplexing a single `dot` unit over nine cycles. It replaces nine parallel dot units with one, trading latency for area.
- Operands are captured with a valid/ready handshake, and results are presented with a valid/ready handshake.
- It sits between the operand source (register file or host interface) and any downstream consumer of the result matrix.

Parameters:
- ENTRY_SIZE, 5, width of each unsigned entry of A and B
- RESENTRY_SIZE, 9, width of each entry of C
- VECTOR_SIZE, 3*ENTRY_SIZE, width of one packed operand vector
- RESVECTOR_SIZE, 3*RESENTRY_SIZE, width of one packed result row

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands present on matrixA*/matrixB*
- in_ready  out  1  block can accept operands
- matrixAv1, matrixAv2, matrixAv3  in  VECTOR_SIZE each  rows of A
- matrixBv1, matrixBv2, matrixBv3  in  VECTOR_SIZE each  columns of B; C[i][j] = dot(Av_i, Bv_j)
- out_valid  out  1  matrixC* holds a complete result
- out_ready  in  1  consumer accepts result
- busy  out  1  high in COMPUTE state
- matrixCv1, matrixCv2, matrixCv3  out  RESVECTOR_SIZE each  registered result rows

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Packing: entry 0 of each vector occupies the MSBs, i.e. [VECTOR_SIZE-1 : VECTOR_SIZE-ENTRY_SIZE]. C rows are packed {c_i1, c_i2, c_i3}, with c_i1 in the MSBs.
- Arithmetic: entries are unsigned. Each C entry is (a0*b0 + a1*b1 + a2*b2) mod 2^RESENTRY_SIZE, silently truncated with no overflow flag.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, register all six operand vectors, clear all nine C registers to 0, set idx=0, go to COMPUTE.
  - COMPUTE: in_ready=0, busy=1. Each cycle the dot unit is fed row idx/3 of A and column idx%3 of B, and its product is written to C[idx/3][idx%3]. idx increments. When the write for idx=8 occurs, go to DONE. in_valid is ignored; operand registers do not change.
  - DONE: out_valid=1, C held stable. On out_ready, go to IDLE. out_valid stays high until that handshake (no drop, no overwrite).
- Latency:
  - Handshake accepted at edge T → C[0][0] written at T+1, C[2][2] written at T+9.
  - out_valid=1 from T+9 (combinationally from the DONE state, visible in the cycle after edge T+9).
  - Throughput: one matrix per 11 cycles minimum (accept, 9 compute, result handshake).
- No overlap: a new operand set cannot be accepted in the same cycle a result is consumed. in_ready rises the cycle after the out_ready handshake.
- While out_valid=0, matrixC* contents are unspecified to the consumer. In practice they show partial results, or 0 after reset.
- Reset values: state=IDLE, idx=0, in_ready=1, out_valid=0, busy=0, all matrixC*=0, operand registers=0.
- Reset at any time, including mid-COMPUTE or in DONE, discards the operation. The cycle after reset deasserts, the block is in IDLE with the reset values above.
- idx is a 4-bit counter. Values 9..15 are unreachable; if ever reached, the block forces DONE.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, COMPUTE=2'd1, DONE=2'd2
  - constant LAST_IDX=8
  - the vector-slice convention (entry k at [VECTOR_SIZE-1-k*ENTRY_SIZE -: ENTRY_SIZE])
- One sub-module: the existing `dot` (ENTRY_SIZE, RESENTRY_SIZE), instantiated once.
- Operand muxing, index counter, FSM and result register bank live in this module.

Test Plan:
- A=identity (1,0,0/0,1,0/0,0,1), B columns = (1,2,3),(4,5,6),(7,8,9) → after handshake, out_valid rises exactly 9 cycles later. matrixCv1 = {1,4,7}, matrixCv2 = {2,5,8}, matrixCv3 = {3,6,9}.
- All A entries 1, all B entries 2 → every C entry 6; busy high for exactly 9 cycles.
- All entries 31 → every C entry 2883 mod 512 = 323 (truncation check).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → out_valid and C stay stable and in_ready stays 0. Then out_ready=1 → IDLE next cycle, and new operands are accepted on the following handshake.
- Reset asserted on the 4th COMPUTE cycle → next cycle shows in_ready=1, out_valid=0, busy=0, all C=0. A fresh operation then completes with correct results.
- Back-to-back: two operand sets with out_ready tied 1 → second result correct. The second accept occurs no earlier than 11 cycles after the first.

Source files
------------

// File: rtl/matmul3_sequencer_pkg.sv
// Shared definitions for the 3x3 matrix-multiply sequencer: FSM encoding,
// last compute index and the operand-vector slicing convention.
package matmul3_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'd8;

  // Entry k of a packed vector sits at [msb -: ent_w]; entry 0 holds the MSBs.
  function automatic int entry_msb(input int k, input int vec_w, input int ent_w);
    return vec_w - 1 - k * ent_w;
  endfunction

endpackage

// File: rtl/matmul3_sequencer_dot.sv
// Three-term unsigned dot product, truncated to RESENTRY_SIZE bits.
module dot
  import matmul3_sequencer_pkg::*;
#(
  parameter  int ENTRY_SIZE    = 5,
  parameter  int RESENTRY_SIZE = 9,
  localparam int VECTOR_SIZE   = 3 * ENTRY_SIZE
) (
  input  logic [VECTOR_SIZE-1:0]   a_i,
  input  logic [VECTOR_SIZE-1:0]   b_i,
  output logic [RESENTRY_SIZE-1:0] res_o
);

  // Accumulate wide enough that only the final truncation drops bits.
  localparam int PW = (2 * ENTRY_SIZE + 2 > RESENTRY_SIZE) ? 2 * ENTRY_SIZE + 2 : RESENTRY_SIZE;

  logic [PW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int k = 0; k < 3; k++) begin
      sum = sum + PW'(a_i[entry_msb(k, VECTOR_SIZE, ENTRY_SIZE) -: ENTRY_SIZE])
                * PW'(b_i[entry_msb(k, VECTOR_SIZE, ENTRY_SIZE) -: ENTRY_SIZE]);
    end
  end

  assign res_o = sum[RESENTRY_SIZE-1:0];

endmodule

// File: rtl/matmul3_sequencer.sv
// 3x3 matrix multiply C = A*B using one shared dot unit over nine cycles,
// with valid/ready handshakes on operands and result.
module matmul3_sequencer
  import matmul3_sequencer_pkg::*;
#(
  parameter int ENTRY_SIZE     = 5,
  parameter int RESENTRY_SIZE  = 9,
  parameter int VECTOR_SIZE    = 3 * ENTRY_SIZE,
  parameter int RESVECTOR_SIZE = 3 * RESENTRY_SIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VECTOR_SIZE-1:0]    matrixAv1,
  input  logic [VECTOR_SIZE-1:0]    matrixAv2,
  input  logic [VECTOR_SIZE-1:0]    matrixAv3,
  input  logic [VECTOR_SIZE-1:0]    matrixBv1,
  input  logic [VECTOR_SIZE-1:0]    matrixBv2,
  input  logic [VECTOR_SIZE-1:0]    matrixBv3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [RESVECTOR_SIZE-1:0] matrixCv1,
  output logic [RESVECTOR_SIZE-1:0] matrixCv2,
  output logic [RESVECTOR_SIZE-1:0] matrixCv3
);

  state_e                                  state_q;
  logic [3:0]                              idx_q;
  logic                                    in_ready_q, out_valid_q, busy_q;
  logic [2:0][VECTOR_SIZE-1:0]             a_q, b_q;
  logic [2:0][2:0][RESENTRY_SIZE-1:0]      c_q;

  logic [1:0]               row, col;
  logic [VECTOR_SIZE-1:0]   op_a, op_b;
  logic [RESENTRY_SIZE-1:0] dot_res;

  assign row = 2'(idx_q / 4'd3);
  assign col = 2'(idx_q % 4'd3);

  // Out-of-range indices never write, so feed zeros rather than a bogus select.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (idx_q <= LAST_IDX) begin
      op_a = a_q[row];
      op_b = b_q[col];
    end
  end

  dot #(
    .ENTRY_SIZE   (ENTRY_SIZE),
    .RESENTRY_SIZE(RESENTRY_SIZE)
  ) u_dot (
    .a_i  (op_a),
    .b_i  (op_b),
    .res_o(dot_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= {matrixAv3, matrixAv2, matrixAv1};
            b_q        <= {matrixBv3, matrixBv2, matrixBv1};
            c_q        <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (idx_q > LAST_IDX) begin
            idx_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            c_q[row][col] <= dot_res;
            idx_q         <= idx_q + 4'd1;
            if (idx_q == LAST_IDX) begin
              idx_q       <= '0;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          idx_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign matrixCv1 = {c_q[0][0], c_q[0][1], c_q[0][2]};
  assign matrixCv2 = {c_q[1][0], c_q[1][1], c_q[1][2]};
  assign matrixCv3 = {c_q[2][0], c_q[2][1], c_q[2][2]};

endmodule

// File: tb/tb_matmul3_sequencer.sv
// Self-checking bench for matmul3_sequencer against a plain-arithmetic matrix model.
module tb_matmul3_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [14:0] matrixAv1 = '0, matrixAv2 = '0, matrixAv3 = '0;
  logic [14:0] matrixBv1 = '0, matrixBv2 = '0, matrixBv3 = '0;
  logic [26:0] matrixCv1, matrixCv2, matrixCv3;

  int pass_cnt = 0, total_cnt = 0, cyc = 0;
  int ma[3][3];  // ma[i][k] = A row i, entry k
  int mb[3][3];  // mb[j][k] = B column j, entry k

  matmul3_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .matrixAv1(matrixAv1), .matrixAv2(matrixAv2), .matrixAv3(matrixAv3),
    .matrixBv1(matrixBv1), .matrixBv2(matrixBv2), .matrixBv3(matrixBv3),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .matrixCv1(matrixCv1), .matrixCv2(matrixCv2), .matrixCv3(matrixCv3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [80:0] model_c();
    logic [80:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += ma[i][k] * mb[j][k];
        r[(8 - (i * 3 + j)) * 9 +: 9] = 9'(s % 512);
      end
    return r;
  endfunction

  function automatic logic [14:0] pack_v(input int v0, input int v1, input int v2);
    return {5'(v0), 5'(v1), 5'(v2)};
  endfunction

  function automatic logic [80:0] cur_c();
    return {matrixCv1, matrixCv2, matrixCv3};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    matrixAv1 = pack_v(ma[0][0], ma[0][1], ma[0][2]);
    matrixAv2 = pack_v(ma[1][0], ma[1][1], ma[1][2]);
    matrixAv3 = pack_v(ma[2][0], ma[2][1], ma[2][2]);
    matrixBv1 = pack_v(mb[0][0], mb[0][1], mb[0][2]);
    matrixBv2 = pack_v(mb[1][0], mb[1][1], mb[1][2]);
    matrixBv3 = pack_v(mb[2][0], mb[2][1], mb[2][2]);
  endtask

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        ma[i][k] = av;
        mb[i][k] = bv;
      end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        ma[i][k] = int'($urandom_range(0, 31));
        mb[i][k] = int'($urandom_range(0, 31));
      end
  endtask

  // Present operands until accepted (bounded), then drop in_valid.
  task automatic accept();
    int n;
    drive_ops();
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    step();
    in_valid = 1'b0;
  endtask

  // Count cycles from acceptance to out_valid, and busy cycles seen on the way.
  task automatic wait_out(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    total_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_flags got %b want 100", {in_ready, out_valid, busy});
    else pass_cnt++;
    total_cnt++;
    if (cur_c() !== 81'd0) $display("FAIL reset_c got %h want 0", cur_c());
    else pass_cnt++;
  endtask

  task automatic test_identity();
    int lat, bcnt;
    logic [80:0] exp_c;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        ma[i][k] = (i == k) ? 1 : 0;
        mb[i][k] = i * 3 + k + 1;
      end
    exp_c = model_c();
    accept();
    wait_out(lat, bcnt);
    total_cnt++;
    if (lat !== 9) $display("FAIL identity_latency got %0d want 9", lat);
    else pass_cnt++;
    total_cnt++;
    if (cur_c() !== exp_c) $display("FAIL identity_c got %h want %h", cur_c(), exp_c);
    else pass_cnt++;
    total_cnt++;
    if (matrixCv1 !== {9'd1, 9'd4, 9'd7}) $display("FAIL identity_row1 got %h want %h", matrixCv1, {9'd1, 9'd4, 9'd7});
    else pass_cnt++;
    release_result();
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL identity_release got %b want 10", {in_ready, out_valid});
    else pass_cnt++;
  endtask

  task automatic test_ones_twos();
    int lat, bcnt;
    fill(1, 2);
    accept();
    wait_out(lat, bcnt);
    total_cnt++;
    if (bcnt !== 9) $display("FAIL ones_busy_cycles got %0d want 9", bcnt);
    else pass_cnt++;
    total_cnt++;
    if (cur_c() !== {9{9'd6}}) $display("FAIL ones_c got %h want %h", cur_c(), {9{9'd6}});
    else pass_cnt++;
    release_result();
  endtask

  task automatic test_truncation();
    int lat, bcnt;
    fill(31, 31);
    accept();
    wait_out(lat, bcnt);
    total_cnt++;
    if (cur_c() !== {9{9'd323}}) $display("FAIL trunc_c got %h want %h", cur_c(), {9{9'd323}});
    else pass_cnt++;
    release_result();
  endtask

  task automatic test_backpressure();
    int lat, bcnt;
    logic [80:0] exp_c;
    fill_rand();
    exp_c = model_c();
    accept();
    wait_out(lat, bcnt);
    fill_rand();
    drive_ops();
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b10) $display("FAIL bp_flags cyc%0d got %b want 10", c, {out_valid, in_ready});
      else pass_cnt++;
      total_cnt++;
      if (cur_c() !== exp_c) $display("FAIL bp_hold cyc%0d got %h want %h", c, cur_c(), exp_c);
      else pass_cnt++;
      step();
    end
    exp_c = model_c();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL bp_idle got %b want 100", {in_ready, out_valid, busy});
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL bp_new_accept got busy=%b want 1", busy);
    else pass_cnt++;
    wait_out(lat, bcnt);
    total_cnt++;
    if (cur_c() !== exp_c) $display("FAIL bp_new_c got %h want %h", cur_c(), exp_c);
    else pass_cnt++;
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    logic [80:0] exp_c;
    fill_rand();
    accept();
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL rstmid_flags got %b want 100", {in_ready, out_valid, busy});
    else pass_cnt++;
    total_cnt++;
    if (cur_c() !== 81'd0) $display("FAIL rstmid_c got %h want 0", cur_c());
    else pass_cnt++;
    fill_rand();
    exp_c = model_c();
    accept();
    wait_out(lat, bcnt);
    total_cnt++;
    if (lat !== 9 || cur_c() !== exp_c) $display("FAIL rstmid_fresh lat %0d c %h want lat 9 c %h", lat, cur_c(), exp_c);
    else pass_cnt++;
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [80:0] exp1, exp2;
    logic [80:0] got[2];
    int acc[2];
    int nacc, nres;
    acc[0] = 0; acc[1] = 0; got[0] = '0; got[1] = '0;
    fill_rand();
    drive_ops();
    exp1 = model_c();
    fill_rand();
    exp2 = model_c();
    in_valid = 1'b1;
    out_ready = 1'b1;
    nacc = 0;
    nres = 0;
    for (int it = 0; it < 60 && nres < 2; it++) begin
      if (out_valid) begin got[nres] = cur_c(); nres++; end
      if (in_valid && in_ready && nacc < 2) begin
        acc[nacc] = cyc;
        nacc++;
        step();
        if (nacc == 1) drive_ops();
        else in_valid = 1'b0;
      end else step();
    end
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    total_cnt++;
    if (nres !== 2 || got[0] !== exp1) $display("FAIL b2b_first results %0d c %h want %h", nres, got[0], exp1);
    else pass_cnt++;
    total_cnt++;
    if (got[1] !== exp2) $display("FAIL b2b_second got %h want %h", got[1], exp2);
    else pass_cnt++;
    total_cnt++;
    if (nacc !== 2 || acc[1] - acc[0] < 11) $display("FAIL b2b_spacing got %0d accepts gap %0d want gap >= 11", nacc, acc[1] - acc[0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, bcnt, hold;
    logic [80:0] exp_c;
    for (int r = 0; r < 6; r++) begin
      fill_rand();
      exp_c = model_c();
      accept();
      wait_out(lat, bcnt);
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) step();
      total_cnt++;
      if (lat !== 9 || cur_c() !== exp_c || out_valid !== 1'b1)
        $display("FAIL random%0d lat %0d ov %b c %h want lat 9 ov 1 c %h", r, lat, out_valid, cur_c(), exp_c);
      else pass_cnt++;
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_ones_twos();
    test_truncation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
